// File: rtl/bse_pkg.sv
// Shared types and helpers for the binary search engine.
package bse_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      CMP   = 2'd2,
      DONE  = 2'd3
   } bse_state_t;

   // Midpoint without forming lo+hi, so it cannot overflow the address width.
   function automatic logic [31:0] mid_f(input logic [31:0] lo, input logic [31:0] hi);
      return lo + ((hi - lo) >> 1);
   endfunction

endpackage

// File: rtl/bse_datapath.sv
// Search datapath: latched target, bounds, probe address, result and compare flags.
module bse_datapath
   import bse_pkg::*;
#(
   parameter int W  = 8,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          step_lo,
   input  logic          step_hi,
   input  logic          capture,
   input  logic [W-1:0]  target,
   input  logic [W-1:0]  mem_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [AW-1:0] result_addr,
   output logic          eq,
   output logic          lt,
   output logic          gt,
   output logic          lo_hit,
   output logic          hi_hit
);

   logic [W-1:0]  tgt_q;
   logic [AW-1:0] lo_q;
   logic [AW-1:0] hi_q;
   logic [AW-1:0] lo_step;
   logic [AW-1:0] hi_step;

   assign lo_step = mem_addr + AW'(1);
   assign hi_step = mem_addr - AW'(1);

   // Unsigned compares of the returned word against the latched target.
   assign eq     = (mem_rdata == tgt_q);
   assign lt     = (mem_rdata <  tgt_q);
   assign gt     = (mem_rdata >  tgt_q);
   assign lo_hit = (mem_addr == lo_q);
   assign hi_hit = (mem_addr == hi_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         tgt_q    <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         mem_addr <= '0;
      end else if (load) begin
         tgt_q    <= target;
         lo_q     <= '0;
         hi_q     <= '1;
         mem_addr <= AW'(mid_f(32'(0), 32'({AW{1'b1}})));
      end else if (step_lo) begin
         lo_q     <= lo_step;
         mem_addr <= AW'(mid_f(32'(lo_step), 32'(hi_q)));
      end else if (step_hi) begin
         hi_q     <= hi_step;
         mem_addr <= AW'(mid_f(32'(lo_q), 32'(hi_step)));
      end
   end

   // Result survives the next start so it stays readable until a new match lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_addr <= '0;
      end else if (capture) begin
         result_addr <= mem_addr;
      end
   end

endmodule

// File: rtl/binary_search_engine.sv
// Binary search over a sorted synchronous-read RAM: FSM, read-latency timer, probe count.
//
//   state | meaning
//   IDLE  | waiting for start; target latched on acceptance
//   PROBE | address on the RAM, waiting RD_LAT cycles for data
//   CMP   | compare returned word, narrow range or finish
//   DONE  | result presented until start is released
module binary_search_engine
   import bse_pkg::*;
#(
   parameter int W      = 8,
   parameter int AW     = 5,
   parameter int RD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [W-1:0]            target,
   output logic [AW-1:0]           mem_addr,
   input  logic [W-1:0]            mem_rdata,
   output logic                    busy,
   output logic                    done,
   output logic                    found,
   output logic                    not_found,
   output logic [AW-1:0]           result_addr,
   output logic [$clog2(AW+2)-1:0] iter_count
);

   localparam int IW = $clog2(AW + 2);
   localparam int WW = 2;

   bse_state_t    state_q;
   bse_state_t    state_d;
   logic [WW-1:0] wait_q;
   logic [IW-1:0] iter_q;
   logic          match_q;

   logic load;
   logic step_lo;
   logic step_hi;
   logic capture;
   logic finish;
   logic eq;
   logic lt;
   logic gt;
   logic lo_hit;
   logic hi_hit;

   bse_datapath #(
      .W  (W),
      .AW (AW)
   ) u_datapath (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .step_lo     (step_lo),
      .step_hi     (step_hi),
      .capture     (capture),
      .target      (target),
      .mem_rdata   (mem_rdata),
      .mem_addr    (mem_addr),
      .result_addr (result_addr),
      .eq          (eq),
      .lt          (lt),
      .gt          (gt),
      .lo_hit      (lo_hit),
      .hi_hit      (hi_hit)
   );

   // A miss is final once the bound on the side we would move past is the probe itself.
   assign finish = eq | (lt & hi_hit) | (gt & lo_hit);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = PROBE;
         PROBE:   if (wait_q == '0) state_d = CMP;
         CMP:     state_d = finish ? DONE : PROBE;
         DONE:    if (!start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load      = 1'b0;
      step_lo   = 1'b0;
      step_hi   = 1'b0;
      capture   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      found     = 1'b0;
      not_found = 1'b0;
      unique case (state_q)
         IDLE: load = start;
         PROBE: busy = 1'b1;
         CMP: begin
            busy    = 1'b1;
            capture = eq;
            step_lo = lt & ~hi_hit;
            step_hi = gt & ~lo_hit;
         end
         DONE: begin
            done      = 1'b1;
            found     = match_q;
            not_found = ~match_q;
         end
         default: ;
      endcase
   end

   // Read-latency timer: reloaded on every new probe address, terminal count at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q <= '0;
      end else if (load || step_lo || step_hi) begin
         wait_q <= WW'(RD_LAT - 1);
      end else if (state_q == PROBE && wait_q != '0) begin
         wait_q <= wait_q - WW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         iter_q  <= '0;
         match_q <= 1'b0;
      end else if (load) begin
         iter_q  <= '0;
         match_q <= 1'b0;
      end else if (state_q == CMP) begin
         iter_q  <= iter_q + IW'(1);
         match_q <= eq;
      end
   end

   assign iter_count = iter_q;

endmodule

// File: tb/tb_binary_search_engine.sv
// Directed bench: two engines (RD_LAT=1 and RD_LAT=3) over mem[i]=2*i+1, checked one after the other.
module tb_binary_search_engine;

   logic       clk;
   logic       reset_v     [2];
   logic       start_v     [2];
   logic [7:0] target_v    [2];
   logic [4:0] mem_addr_v  [2];
   logic [7:0] rdata_v     [2];
   logic       busy_v      [2];
   logic       done_v      [2];
   logic       found_v     [2];
   logic       not_found_v [2];
   logic [4:0] result_v    [2];
   logic [2:0] iter_v      [2];

   logic [7:0] pipe0;
   logic [7:0] pipe1 [3];

   int checks   = 0;
   int failures = 0;
   int cur_d    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   binary_search_engine #(.W(8), .AW(5), .RD_LAT(1)) u_dut1 (
      .clk (clk), .reset (reset_v[0]), .start (start_v[0]), .target (target_v[0]),
      .mem_addr (mem_addr_v[0]), .mem_rdata (rdata_v[0]), .busy (busy_v[0]),
      .done (done_v[0]), .found (found_v[0]), .not_found (not_found_v[0]),
      .result_addr (result_v[0]), .iter_count (iter_v[0])
   );

   binary_search_engine #(.W(8), .AW(5), .RD_LAT(3)) u_dut3 (
      .clk (clk), .reset (reset_v[1]), .start (start_v[1]), .target (target_v[1]),
      .mem_addr (mem_addr_v[1]), .mem_rdata (rdata_v[1]), .busy (busy_v[1]),
      .done (done_v[1]), .found (found_v[1]), .not_found (not_found_v[1]),
      .result_addr (result_v[1]), .iter_count (iter_v[1])
   );

   function automatic logic [7:0] ram_f(input logic [4:0] a);
      return {2'b00, a, 1'b1};
   endfunction

   always @(posedge clk) begin
      pipe0    <= ram_f(mem_addr_v[0]);
      pipe1[0] <= ram_f(mem_addr_v[1]);
      pipe1[1] <= pipe1[0];
      pipe1[2] <= pipe1[1];
   end
   assign rdata_v[0] = pipe0;
   assign rdata_v[1] = pipe1[2];

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s dut_lat%0d got=%0d want=%0d", tag, (cur_d == 0) ? 1 : 3, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input int d, input logic [4:0] exp_result);
      chk_eq("rst_mem_addr", mem_addr_v[d], 0);
      chk_eq("rst_busy", busy_v[d], 0);
      chk_eq("rst_done", done_v[d], 0);
      chk_eq("rst_found", found_v[d], 0);
      chk_eq("rst_not_found", not_found_v[d], 0);
      chk_eq("rst_result_addr", result_v[d], exp_result);
      chk_eq("rst_iter_count", iter_v[d], 0);
   endtask

   // Raise start, count edges (sampling edge included) until done, then check the result.
   task automatic run_search(input int d, input logic [7:0] tgt, input logic exp_found,
                             input logic [4:0] exp_addr, input int exp_iter, input int exp_edges);
      int edges;
      @(negedge clk);
      target_v[d] = tgt;
      start_v[d]  = 1'b1;
      @(posedge clk);
      #1;
      edges = 1;
      chk_eq("busy_after_start", busy_v[d], 1);
      target_v[d] = ~tgt;
      while (!done_v[d] && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk_eq("done_reached", done_v[d], 1);
      if (exp_edges > 0) chk_eq("done_latency", edges, exp_edges);
      chk_eq("found", found_v[d], exp_found);
      chk_eq("not_found", not_found_v[d], !exp_found);
      chk_eq("busy_in_done", busy_v[d], 0);
      chk_eq("iter_count", iter_v[d], exp_iter);
      if (exp_found) chk_eq("result_addr", result_v[d], exp_addr);
   endtask

   task automatic release_start(input int d);
      @(negedge clk);
      start_v[d] = 1'b0;
      @(posedge clk);
      #1;
      chk_eq("idle_done", done_v[d], 0);
      chk_eq("idle_found", found_v[d], 0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset_v[i]  = 1'b1;
         start_v[i]  = 1'b0;
         target_v[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         cur_d = i;
         check_idle_outputs(i, 5'd0);
      end
      @(negedge clk);
      reset_v[0] = 1'b0;
      reset_v[1] = 1'b0;

      for (int d = 0; d < 2; d++) begin
         int lat;
         cur_d = d;
         lat   = (d == 0) ? 1 : 3;

         run_search(d, 8'd31, 1'b1, 5'd15, 1, lat + 2);
         release_start(d);

         run_search(d, 8'd63, 1'b1, 5'd31, 6, 6 * (lat + 1) + 1);
         release_start(d);

         run_search(d, 8'd0, 1'b0, 5'd0, 5, -1);
         chk_eq("no_underflow_addr", mem_addr_v[d], 0);
         release_start(d);

         run_search(d, 8'd64, 1'b0, 5'd0, 6, -1);
         chk_eq("last_probe_addr", mem_addr_v[d], 31);
         release_start(d);

         run_search(d, 8'd2, 1'b0, 5'd0, 5, -1);
         release_start(d);

         // Start held through DONE must not retrigger.
         run_search(d, 8'd63, 1'b1, 5'd31, 6, -1);
         repeat (5) @(posedge clk);
         #1;
         chk_eq("hold_done", done_v[d], 1);
         chk_eq("hold_found", found_v[d], 1);
         chk_eq("hold_iter", iter_v[d], 6);
         release_start(d);
         chk_eq("idle_busy", busy_v[d], 0);
         chk_eq("idle_result_hold", result_v[d], 31);

         run_search(d, 8'd1, 1'b1, 5'd0, 5, -1);
         release_start(d);

         run_search(d, 8'd47, 1'b1, 5'd23, 2, -1);
         release_start(d);

         // Reset while the first probe is in flight.
         @(negedge clk);
         target_v[d] = 8'd63;
         start_v[d]  = 1'b1;
         @(posedge clk);
         #1;
         chk_eq("pre_reset_busy", busy_v[d], 1);
         @(negedge clk);
         reset_v[d] = 1'b1;
         start_v[d] = 1'b0;
         @(posedge clk);
         #1;
         check_idle_outputs(d, 5'd0);
         @(negedge clk);
         reset_v[d] = 1'b0;

         run_search(d, 8'd33, 1'b1, 5'd16, 5, -1);
         release_start(d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
